// File: rtl/branch_flag_if.sv
// Valid/ready bus of the branch flag unit: compare request in, {Z,C,S,V} result plus tag out.
interface branch_flag_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       flags;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output flush, in_valid, src_a, src_b, in_tag, out_ready,
        input  in_ready, out_valid, flags, out_tag
    );

    modport slave (
        input  flush, in_valid, src_a, src_b, in_tag, out_ready,
        output in_ready, out_valid, flags, out_tag
    );
endinterface

// File: rtl/branch_flag_unit.sv
// Two-stage compare pipeline producing {Z,C,S,V} of src_a-src_b for branch resolution.
// Optional FLAG_STATS_EN adds stat_cmp/stat_eq transfer counters.
module branch_flag_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    branch_flag_if.slave bus
`ifdef FLAG_STATS_EN
    ,
    output logic [31:0]  stat_cmp,
    output logic [31:0]  stat_eq
`endif
);
    localparam int unsigned SUM_W = WIDTH + 1;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0]       flags_q, flags_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic [SUM_W-1:0] sum;
    logic [3:0]       flags_new;

    // Stage-advance chain; in_ready depends only on state and flush.
    assign s2_adv       = ~out_valid_q | bus.out_ready;
    assign s1_adv       = ~s1_valid_q | s2_adv;
    assign bus.in_ready = s1_adv & ~bus.flush;
    assign accept       = bus.in_valid & s1_adv & ~bus.flush;

    // Subtract via a + ~b + 1 so the carry-out gives the inverted borrow.
    always_comb begin
        sum          = {1'b0, a_q} + {1'b0, ~b_q} + SUM_W'(1);
        flags_new[3] = (sum[WIDTH-1:0] == '0);
        flags_new[2] = ~sum[WIDTH];
        flags_new[1] = sum[WIDTH-1];
        flags_new[0] = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (sum[WIDTH-1] != a_q[WIDTH-1]);
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        s1_tag_d    = s1_tag_q;
        out_valid_d = out_valid_q;
        flags_d     = flags_q;
        out_tag_d   = out_tag_q;

        if (s1_adv) s1_valid_d = accept;
        if (accept) begin
            a_d      = bus.src_a;
            b_d      = bus.src_b;
            s1_tag_d = bus.in_tag;
        end

        if (s2_adv) out_valid_d = s1_valid_q;
        if (s2_adv & s1_valid_q) begin
            flags_d   = flags_new;
            out_tag_d = s1_tag_q;
        end

        // Flush kills occupancy only; data registers may keep stale values.
        if (bus.flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s1_tag_q    <= '0;
            out_valid_q <= 1'b0;
            flags_q     <= 4'b0;
            out_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s1_tag_q    <= s1_tag_d;
            out_valid_q <= out_valid_d;
            flags_q     <= flags_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.flags     = flags_q;
    assign bus.out_tag   = out_tag_q;

`ifdef FLAG_STATS_EN
    logic [31:0] stat_cmp_q, stat_cmp_d;
    logic [31:0] stat_eq_q, stat_eq_d;

    // Count completed result transfers and the equal ones among them.
    always_comb begin
        stat_cmp_d = stat_cmp_q;
        stat_eq_d  = stat_eq_q;
        if (out_valid_q & bus.out_ready) begin
            stat_cmp_d = stat_cmp_q + 32'd1;
            if (flags_q[3]) stat_eq_d = stat_eq_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_cmp_q <= 32'd0;
            stat_eq_q  <= 32'd0;
        end else begin
            stat_cmp_q <= stat_cmp_d;
            stat_eq_q  <= stat_eq_d;
        end
    end

    assign stat_cmp = stat_cmp_q;
    assign stat_eq  = stat_eq_q;
`endif
endmodule

// File: tb/tb_branch_flag_unit.sv
// Scoreboard bench for branch_flag_unit: directed scenarios plus randomized traffic
// checked against an arithmetic reference of the flag rules.
module tb_branch_flag_unit;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned TAG_W = 32;

    typedef struct {
        logic [3:0]       flags;
        logic [TAG_W-1:0] tag;
        int               cyc;
        bit               exact;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    branch_flag_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();
`ifdef FLAG_STATS_EN
    logic [31:0] stat_cmp;
    logic [31:0] stat_eq;
`endif

    branch_flag_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FLAG_STATS_EN
        ,
        .stat_cmp (stat_cmp),
        .stat_eq  (stat_eq)
`endif
    );

    exp_t sb[$];
    int   checks     = 0;
    int   passes     = 0;
    int   cycle      = 0;
    int   accepts    = 0;
    bit   exact_mode = 1'b0;
    int   m_cmp      = 0;
    int   m_eq       = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Flags straight from the arithmetic meaning of the compare.
    function automatic logic [3:0] ref_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] d;
        logic z, c, s, v;
        d = a - b;
        z = (a == b);
        c = (a < b);
        s = d[WIDTH-1];
        v = ($signed(a) < $signed(b)) ^ s;
        return {z, c, s, v};
    endfunction

    // Output monitor: pops the scoreboard on every result transfer.
    exp_t             e;
    int               lat;
    bit               prev_hold = 1'b0;
    logic [3:0]       prev_flags;
    logic [TAG_W-1:0] prev_tag;
    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
            m_cmp     = 0;
            m_eq      = 0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_flags", 64'(bus.flags), 64'(prev_flags));
                check("hold_tag", 64'(bus.out_tag), 64'(prev_tag));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("out_expected", 64'(sb.size() != 0), 64'd1);
                end else begin
                    e   = sb.pop_front();
                    lat = cycle - e.cyc;
                    check("flags", 64'(bus.flags), 64'(e.flags));
                    check("out_tag", 64'(bus.out_tag), 64'(e.tag));
                    if (e.exact) check("latency", 64'(lat), 64'd2);
                    else check("latency_min", 64'(lat >= 2), 64'd1);
                    m_cmp++;
                    if (e.flags[3]) m_eq++;
                end
            end
            prev_hold  = bus.out_valid && !bus.out_ready && !bus.flush;
            prev_flags = bus.flags;
            prev_tag   = bus.out_tag;
        end
    end

    // One clock of stimulus; entered and left at posedge+1.
    task automatic cyc(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [TAG_W-1:0] tag, input bit fl, input bit ordy);
        bus.in_valid  = v;
        bus.src_a     = a;
        bus.src_b     = b;
        bus.in_tag    = tag;
        bus.flush     = fl;
        bus.out_ready = ordy;
        @(negedge clk);
        if (!reset && bus.in_valid && bus.in_ready) begin
            sb.push_back('{ref_flags(a, b), tag, cycle, exact_mode});
            accepts++;
        end
        @(posedge clk);
        if (reset || fl) sb.delete();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [WIDTH-1:0] edge_v[4];
    int               acc0;
    logic [WIDTH-1:0] ra, rb;
    int               sel;

    initial begin
        edge_v[0] = '0;
        edge_v[1] = '1;
        edge_v[2] = {1'b1, {(WIDTH-1){1'b0}}};
        edge_v[3] = {1'b0, {(WIDTH-1){1'b1}}};
        bus.in_valid  = 1'b0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.in_tag    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_flags", 64'(bus.flags), 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef FLAG_STATS_EN
        check("rst_stat_cmp", 64'(stat_cmp), 64'd0);
`endif
        @(posedge clk);
        #1;

        // Directed flag cases, then 8 back-to-back with exact latency.
        exact_mode = 1'b1;
        cyc(1'b1, 32'd5, 32'd5, 32'h0000_1000, 1'b0, 1'b1);
        cyc(1'b1, 32'd1, 32'd2, 32'h0000_1004, 1'b0, 1'b1);
        cyc(1'b1, 32'h8000_0000, 32'd1, 32'h0000_1008, 1'b0, 1'b1);
        idle(3);
        for (int i = 0; i < 8; i++) cyc(1'b1, $urandom, $urandom, TAG_W'(32'h2000 + i), 1'b0, 1'b1);
        idle(3);
        exact_mode = 1'b0;

        // Backpressure: only two compares fit while out_ready is low.
        acc0 = accepts;
        for (int i = 0; i < 5; i++) cyc(1'b1, $urandom, $urandom, TAG_W'(32'h3000 + i), 1'b0, 1'b0);
        check("bp_accepts", 64'(accepts - acc0), 64'd2);
        @(negedge clk);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        idle(4);

        // Flush with both stages full.
        cyc(1'b1, 32'd7, 32'd7, 32'h4000, 1'b0, 1'b0);
        cyc(1'b1, 32'd3, 32'd9, 32'h4004, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.src_a    = 32'd11;
        bus.src_b    = 32'd11;
        bus.in_tag   = 32'h4008;
        bus.flush    = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        sb.delete();
        #1;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        idle(3);

        // Reset in the middle of a stream.
        for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, $urandom, TAG_W'(32'h5000 + i), 1'b0, 1'b1);
        reset = 1'b1;
        cyc(1'b1, 32'd1, 32'd1, 32'h5100, 1'b0, 1'b1);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_flags", 64'(bus.flags), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef FLAG_STATS_EN
        check("mid_rst_stat_cmp", 64'(stat_cmp), 64'd0);
        check("mid_rst_stat_eq", 64'(stat_eq), 64'd0);
`endif
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            ra = $urandom;
            rb = (i < 3) ? ra : ra + WIDTH'(i);
            cyc(1'b1, ra, rb, TAG_W'(32'h6000 + i), 1'b0, 1'b1);
        end
        idle(3);
`ifdef FLAG_STATS_EN
        check("stat_cmp_5", 64'(stat_cmp), 64'd5);
        check("stat_eq_3", 64'(stat_eq), 64'd3);
`endif

        // Randomized traffic with random backpressure and occasional flush.
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 5));
            ra  = $urandom;
            rb  = $urandom;
            if (sel == 0) rb = ra;
            else if (sel == 1) ra = edge_v[$urandom_range(0, 3)];
            else if (sel == 2) rb = edge_v[$urandom_range(0, 3)];
            else if (sel == 3) begin
                ra = edge_v[$urandom_range(0, 3)];
                rb = edge_v[$urandom_range(0, 3)];
            end
            cyc($urandom_range(0, 3) != 0, ra, rb, $urandom,
                $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
        end

        for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1);
        check("drain_empty", 64'(sb.size()), 64'd0);
        idle(2);
`ifdef FLAG_STATS_EN
        check("stat_cmp_end", 64'(stat_cmp), 64'(m_cmp));
        check("stat_eq_end", 64'(stat_eq), 64'(m_eq));
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
